// File: rtl/mem_line_responder.sv
// Backing-store responder for cache line fills and dirty-line writebacks.
// Serves one request at a time with a fixed per-direction latency.
module mem_line_responder #(
  parameter int LINE_BITS   = 512,
  parameter int OFFSET_BITS = 6,
  parameter int MEM_LINES   = 1024,
  parameter int READ_LAT    = 4,
  parameter int WRITE_LAT   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [31:0]          req_addr_i,
  input  logic [LINE_BITS-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_is_write_o,
  output logic [LINE_BITS-1:0] resp_rdata_o,
  output logic                 resp_err_o
);

  localparam int IDX_W   = $clog2(MEM_LINES);
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                 write;
    logic                 err;
    logic [IDX_W-1:0]     idx;
    logic [LINE_BITS-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q;
  logic              resp_is_write_q;
  logic              resp_err_q;
  logic [LINE_BITS-1:0] resp_rdata_q;

  logic [LINE_BITS-1:0] mem [MEM_LINES];

  logic accept;
  logic commit;
  logic addr_err;

  // Any address bit above the line-index field marks the request out of range.
  assign addr_err = (req_addr_i >> (OFFSET_BITS + IDX_W)) != 32'd0;

  assign req_ready_o     = (state_q == S_IDLE) && !rst_i;
  assign accept          = req_valid_i && req_ready_o;
  assign resp_valid_o    = (state_q == S_RESP);
  assign resp_is_write_o = resp_is_write_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign resp_err_o      = resp_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = req_write_i ? WR_LOAD : RD_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      resp_is_write_q <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        resp_is_write_q <= req_q.write;
        resp_err_q      <= req_q.err;
        resp_rdata_q    <= (req_q.write || req_q.err) ? '0 : mem[req_q.idx];
      end
    end
  end

  // Request capture needs no reset: it is only consumed after a fresh acceptance.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_q.write <= req_write_i;
      req_q.err   <= addr_err;
      req_q.idx   <= req_addr_i[OFFSET_BITS +: IDX_W];
      req_q.wdata <= req_wdata_i;
    end
  end

  // A reset on the commit edge discards the write along with the transaction.
  always_ff @(posedge clk_i) begin
    if (commit && !rst_i && req_q.write && !req_q.err)
      mem[req_q.idx] <= req_q.wdata;
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: scoreboard of expected responses
// pushed at issue time, popped and checked when the response appears.
module tb_mem_line_responder;
  localparam int LB = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [LB-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_is_write;
  logic [LB-1:0] resp_rdata;
  logic          resp_err;

  mem_line_responder #(
    .LINE_BITS(LB), .OFFSET_BITS(6), .MEM_LINES(1024), .READ_LAT(4), .WRITE_LAT(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_is_write_o(resp_is_write), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic          err;
    logic [LB-1:0] rdata;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [LB-1:0] model [int];
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected response computed from the reference line model at issue time.
  task automatic push(input logic w, input logic [31:0] a, input logic [LB-1:0] d);
    exp_t e;
    int   idx;
    idx     = int'(a[15:6]);
    e.w     = w;
    e.err   = (a >> 16) != 32'd0;
    e.lat   = w ? 2 : 4;
    e.rdata = '0;
    if (!w && !e.err) e.rdata = model.exists(idx) ? model[idx] : 'x;
    if (w && !e.err) model[idx] = d;
    sb.push_back(e);
  endtask

  // Drive a request and return #1 after the accepting edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [LB-1:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_ready_timeout", {511'd0, req_ready}, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1);
    req_addr  = $urandom;
    req_wdata = {16{$urandom}};
  endtask

  // stall < 0: random resp_ready; otherwise hold resp_ready low for stall cycles.
  task automatic get(input int stall);
    exp_t e;
    int   n, k;
    logic rr;
    e = sb.pop_front();
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!resp_valid && n < 20);
    chk("latency", n, e.lat);
    chk("is_write", {511'd0, resp_is_write}, {511'd0, e.w});
    chk("err", {511'd0, resp_err}, {511'd0, e.err});
    chk("rdata", resp_rdata, e.rdata);
    chk("req_ready_in_resp", {511'd0, req_ready}, 0);
    k = 0;
    do begin
      rr = (stall < 0) ? 1'($urandom_range(0, 1)) : (k >= stall);
      resp_ready = rr;
      @(posedge clk);
      #1;
      if (!rr) begin
        chk("held_valid", {511'd0, resp_valid}, 1);
        chk("held_rdata", resp_rdata, e.rdata);
        chk("held_ready", {511'd0, req_ready}, 0);
      end
      k++;
    end while (!rr && k < 200);
    resp_ready = 1'b0;
    chk("valid_drop", {511'd0, resp_valid}, 0);
    chk("ready_back", {511'd0, req_ready}, 1);
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [LB-1:0] d, input int stall);
    push(w, a, d);
    send(w, a, d);
    get(stall);
  endtask

  task automatic quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk(tag, {511'd0, resp_valid}, 0);
    end
  endtask

  initial begin
    logic [LB-1:0] dbeef, da, db, dc, d1023;
    dbeef = {16{32'hDEADBEEF}};
    da    = {16{32'h0A0A_5555}};
    db    = {16{32'h1234_5678}};
    dc    = {16{32'hCAFE_F00D}};
    d1023 = {8{64'h0123_4567_89AB_CDEF}};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {511'd0, resp_valid}, 0);
    chk("rst_req_ready", {511'd0, req_ready}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", {511'd0, resp_err}, 0);
    chk("rst_is_write", {511'd0, resp_is_write}, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", {511'd0, req_ready}, 1);

    // Write line 1 then read it back, then read with offset bits set
    xact(1'b1, 32'h0000_0040, dbeef, 0);
    xact(1'b0, 32'h0000_0040, '0, 0);
    xact(1'b0, 32'h0000_007F, '0, 0);

    // Out-of-range accesses alias index 0/1 but must not touch storage
    xact(1'b1, 32'h0000_0000, da, 0);
    xact(1'b0, 32'h0001_0000, '0, 0);
    xact(1'b1, 32'h0001_0040, dc, 0);
    xact(1'b0, 32'h0000_0000, '0, 0);
    xact(1'b0, 32'h0000_0040, '0, 0);

    // Backpressure: 10 cycles of resp_ready low, handshake on the 11th
    xact(1'b0, 32'h0000_0040, '0, 10);

    // Write dropped by a reset while still waiting
    xact(1'b1, 32'h0000_0080, db, 0);
    send(1'b1, 32'h0000_0080, dc);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {511'd0, req_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    quiet("rst_mid_no_resp", 6);
    xact(1'b0, 32'h0000_0080, '0, 0);

    // Request coincident with reset is not accepted
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = dc;
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0;
    quiet("rst_req_no_resp", 6);
    xact(1'b0, 32'h0000_0080, '0, 0);

    // Stream with random backpressure
    xact(1'b0, 32'h0000_0000, '0, -1);
    xact(1'b1, 32'h0000_FFC0, d1023, -1);
    xact(1'b0, 32'h0000_0000, '0, -1);
    xact(1'b0, 32'h0000_FFC0, '0, -1);
    for (int i = 0; i < 6; i++) begin
      logic [LB-1:0] rd;
      rd = {16{$urandom}};
      xact(1'b1, (i % 2 == 0) ? 32'h0 : 32'hFFC0, rd, -1);
      xact(1'b0, (i % 2 == 0) ? 32'h0 : 32'hFFC0, '0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1);
  end

endmodule
